rr_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among N requesters. Each grant is held until the owner signals completion, withdraws its request, or exceeds a hold limit. It sits between requesting masters and a single shared datapath resource, and drives the resource's one-hot select and owner index. All arbitration state is registered on one clock.

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 37 +++
 rtl/rr_arbiter.sv | 98 +++++++++
 tb/tb_rr_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbitration definitions: FSM state encoding and the default sizing
// reused by arbiters and their benches.
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int ARB_N_DEFAULT        = 4;
    localparam int ARB_MAX_HOLD_DEFAULT = 16;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo N.
// Purely combinational so it can be exercised on its own.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = ARB_N_DEFAULT
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] sel,
    output logic                 valid
);

    localparam int IDW = $clog2(N);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;

    // NOTE: every variable assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        req_dbl = {req, req};
        req_rot = N'(req_dbl >> ptr);
        valid   = |req;
        off     = '0;
        // Descending scan so the lowest offset from ptr wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) off = IDW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDW + 1)'(N)) sum = sum - (IDW + 1)'(N);
        sel = sum[IDW-1:0];
    end

endmodule : rr_pick

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grant held until done, request withdrawal or the
// MAX_HOLD limit; the released owner drops to lowest priority.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEFAULT,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 grant_valid,
    output logic                 timeout
);

    localparam int IDW = $clog2(N);
    localparam int CW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic           timeout_q, timeout_d;

    logic [IDW-1:0] pick_sel;
    logic           pick_valid;
    logic           hold_limit;

    rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .sel   (pick_sel),
        .valid (pick_valid)
    );

    assign hold_limit = (MAX_HOLD != 0) && (cnt_q == CW'(MAX_HOLD - 1));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d    = {{(N-1){1'b0}}, 1'b1} << pick_sel;
                    grant_id_d = pick_sel;
                    cnt_d      = '0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done || !req[grant_id_q] || hold_limit) begin
                    // Only a pure hold-limit release reports a timeout.
                    timeout_d = !done && req[grant_id_q];
                    grant_d   = '0;
                    state_d   = ST_IDLE;
                    ptr_d     = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + 1'b1;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = |grant_q;
    assign timeout     = timeout_q;

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios then random traffic, all compared
// against an owner/hold-count reference model.
module tb_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;
    localparam int IDW      = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;
    logic           timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the resource, for how many visible cycles,
    // and where the next scan starts.
    int m_owner   = -1;
    int m_held    = 0;
    int m_next    = 0;
    int m_last    = 0;
    bit m_timeout = 1'b0;

    rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_held    = 0;
        m_next    = 0;
        m_last    = 0;
        m_timeout = 1'b0;
    endtask

    task automatic model_release();
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic d, input logic rs);
        m_timeout = 1'b0;
        if (rs) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_next + k) % N;
                if (r[idx]) begin
                    m_owner = idx;
                    m_last  = idx;
                    m_held  = 1;
                    break;
                end
            end
        end else if (d || !r[m_owner]) begin
            model_release();
        end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
            model_release();
            m_timeout = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] exp_grant;
        exp_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
        check({tag, ".grant_id"}, 32'(grant_id), 32'(m_last));
        check({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
        check({tag, ".timeout"}, 32'(timeout), 32'(m_timeout));
        check({tag, ".excl"}, 32'(timeout & grant_valid), 32'd0);
    endtask

    // Drive inputs away from the edge, clock once, then compare 1 time unit later.
    task automatic step(input string tag, input logic [N-1:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d, rst);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [N-1:0] rr;
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;

        // Reset held with all requests pending.
        repeat (3) step("reset", 4'b1111, 1'b0);
        rst = 1'b0;
        step("first", 4'b1111, 1'b0);
        check("first_grant", 32'(grant), 32'h1);

        // Full rotation with done in each grant cycle.
        for (int g = 1; g <= 4; g++) begin
            step("rot_rel", 4'b1111, 1'b1);
            check("rot_gap", 32'(grant), 32'h0);
            step("rot_gnt", 4'b1111, 1'b0);
            check("rot_seq", 32'(grant), 32'(1 << (g % N)));
        end

        // Owner 2, then release with req=0101: scan wraps to index 0.
        step("skip_rel", 4'b0100, 1'b1);
        step("skip_gnt", 4'b0100, 1'b0);
        check("skip_own2", 32'(grant), 32'h4);
        step("wrap_rel", 4'b0101, 1'b1);
        step("wrap_gnt", 4'b0101, 1'b0);
        check("wrap_skip", 32'(grant), 32'h1);

        // Timeout: requester 1 alone, done never asserted.
        step("to_rel", 4'b0010, 1'b0);
        step("to_gnt", 4'b0010, 1'b0);
        for (int c = 2; c <= MAX_HOLD; c++) step("to_hold", 4'b0010, 1'b0);
        check("to_last_hold", 32'(grant), 32'h2);
        step("to_fire", 4'b0010, 1'b0);
        check("to_pulse", 32'({grant, timeout}), 32'({4'b0000, 1'b1}));
        step("to_regnt", 4'b0010, 1'b0);
        check("to_regrant", 32'({grant, timeout}), 32'({4'b0010, 1'b0}));

        // done in the 16th grant cycle beats the hold limit.
        for (int c = 2; c <= MAX_HOLD; c++) step("dl_hold", 4'b0010, 1'b0);
        step("dl_rel", 4'b0010, 1'b1);
        check("dl_no_timeout", 32'({grant, timeout}), 32'h0);

        // Withdrawal by the owner in its 5th cycle.
        step("wd_gnt", 4'b0010, 1'b0);
        for (int c = 2; c <= 5; c++) step("wd_hold", 4'b0010, 1'b0);
        step("wd_drop", 4'b0000, 1'b0);
        check("wd_release", 32'({grant, timeout}), 32'h0);

        // Async reset between edges while grant=0100.
        step("ar_idle", 4'b0100, 1'b0);
        step("ar_gnt", 4'b0100, 1'b0);
        check("ar_owner", 32'(grant), 32'h4);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("ar_async");
        step("ar_hold", 4'b1100, 1'b0);
        rst = 1'b0;
        step("ar_after", 4'b1100, 1'b0);
        check("ar_from0", 32'(grant), 32'h4);

        // Random traffic: slowly changing requests so holds and timeouts occur.
        rr = 4'b1111;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(9) == 0) rr = N'($urandom);
            rst = ($urandom_range(299) == 0);
            step("rand", rr, ($urandom_range(19) == 0));
        end
        rst = 1'b0;
        step("rand_end", 4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rr_arbiter
